// File: rtl/uart_rx_core.sv
// UART receiver: start/DATA_BITS data (LSB first)/stop frames from an asynchronous rx line,
// presented on a valid/ready interface with framing-error and overrun pulses.
module uart_rx_core #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_rx_meta;
   logic                 r_rx_s;
   logic [CW-1:0]        r_clk_cnt;
   logic [BW-1:0]        r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_valid;
   logic                 r_frame_err;
   logic                 r_overrun;
   logic                 r_deliver;
   logic                 w_cnt_clr;
   logic                 w_sample;
   logic                 w_stop_ok;
   logic                 w_stop_bad;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_sample    = 1'b0;
      w_stop_ok   = 1'b0;
      w_stop_bad  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!r_rx_s) begin
               w_state_nxt = ST_START;
               w_cnt_clr   = 1'b1;
            end
         end
         ST_START: begin
            // A start bit that is already high again at its midpoint is treated as a glitch
            if (r_clk_cnt == CNT_HALF) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (r_clk_cnt == CNT_MAX) begin
               w_cnt_clr = 1'b1;
               w_sample  = 1'b1;
               if (r_bit_cnt == BIT_MAX) begin
                  w_state_nxt = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (r_clk_cnt == CNT_MAX) begin
               w_cnt_clr = 1'b1;
               if (r_rx_s) begin
                  w_stop_ok   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_stop_bad  = 1'b1;
                  w_state_nxt = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            if (r_rx_s) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_clr   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clk_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else begin
         if (w_cnt_clr || r_state == ST_IDLE || r_state == ST_BREAK) begin
            r_clk_cnt <= '0;
         end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
         end
         if (w_sample) begin
            r_shift[r_bit_cnt] <= r_rx_s;
            r_bit_cnt          <= (r_bit_cnt == BIT_MAX) ? '0 : r_bit_cnt + BW'(1);
         end else if (r_state != ST_DATA) begin
            r_bit_cnt <= '0;
         end
      end
   end

   // Delivery happens the cycle after the stop sample; the shift register is idle until then
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         r_deliver   <= 1'b0;
      end else begin
         r_frame_err <= w_stop_bad;
         r_deliver   <= w_stop_ok;
         r_overrun   <= 1'b0;
         if (r_deliver) begin
            if (!r_rx_valid || rx_ready) begin
               r_rx_data  <= r_shift;
               r_rx_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: scoreboard of expected bytes checked at each accepted
// handshake, plus pulse counters checked after each scenario.
module tb_uart_rx_core;

   localparam int unsigned CPB = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;
   int n_acc    = 0;
   int n_ferr   = 0;
   int n_ovr    = 0;

   logic [7:0] sb[$];
   logic [7:0] exp_b;
   logic       hold_prev = 1'b0;
   logic [7:0] prev_data = '0;

   int acc0, ferr0, ovr0;

   uart_rx_core #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_val);
      rx = 1'b0;
      wait_clks(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clks(CPB);
      end
      rx = stop_val;
      wait_clks(CPB);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Output monitor: scoreboard pops on handshake, pulse counting, hold stability
   always @(negedge clk) begin
      if (reset) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check("hold_valid", {31'd0, rx_valid}, 32'd1);
            check("hold_data", {24'd0, rx_data}, {24'd0, prev_data});
         end
         if (rx_valid && rx_ready) begin
            check("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
            if (sb.size() > 0) begin
               exp_b = sb.pop_front();
               check("rx_data", {24'd0, rx_data}, {24'd0, exp_b});
            end
            n_acc++;
         end
         check("flags_exclusive", {31'd0, (frame_err && overrun)}, 32'd0);
         if (frame_err) n_ferr++;
         if (overrun) n_ovr++;
         hold_prev = rx_valid && !rx_ready;
         prev_data = rx_data;
      end
   end

   initial begin
      reset    = 1'b1;
      rx       = 1'b1;
      rx_ready = 1'b1;
      #12;
      check("rst_data", {24'd0, rx_data}, 32'd0);
      check("rst_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_ferr", {31'd0, frame_err}, 32'd0);
      check("rst_ovr", {31'd0, overrun}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      #8;
      reset = 1'b0;
      wait_clks(3);

      // 1: single byte
      acc0 = n_acc; ferr0 = n_ferr; ovr0 = n_ovr;
      sb.push_back(8'hA5);
      send_byte(8'hA5, 1'b1);
      wait_clks(10);
      check("t1_acc", n_acc, acc0 + 1);
      check("t1_ferr", n_ferr, ferr0);
      check("t1_ovr", n_ovr, ovr0);
      check("t1_valid", {31'd0, rx_valid}, 32'd0);

      // 2: back-to-back frames, no idle gap
      acc0 = n_acc;
      sb.push_back(8'h00);
      send_byte(8'h00, 1'b1);
      sb.push_back(8'hFF);
      send_byte(8'hFF, 1'b1);
      wait_clks(10);
      check("t2_acc", n_acc, acc0 + 2);
      check("t2_sb_empty", sb.size(), 0);

      // 3: short low glitch
      acc0 = n_acc; ferr0 = n_ferr; ovr0 = n_ovr;
      rx = 1'b0;
      wait_clks(5);
      check("t3_busy_hi", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      wait_clks(20);
      check("t3_busy_lo", {31'd0, busy}, 32'd0);
      check("t3_acc", n_acc, acc0);
      check("t3_flags", n_ferr + n_ovr, ferr0 + ovr0);

      // 4: stop bit low, line held low
      acc0 = n_acc; ferr0 = n_ferr;
      send_byte(8'h3C, 1'b0);
      wait_clks(40);
      check("t4_ferr", n_ferr, ferr0 + 1);
      check("t4_busy_break", {31'd0, busy}, 32'd1);
      check("t4_valid", {31'd0, rx_valid}, 32'd0);
      rx = 1'b1;
      wait_clks(5);
      check("t4_busy_lo", {31'd0, busy}, 32'd0);
      check("t4_acc", n_acc, acc0);

      // 5: consumer stalled, second byte overruns
      acc0 = n_acc; ovr0 = n_ovr;
      rx_ready = 1'b0;
      sb.push_back(8'h11);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      wait_clks(10);
      check("t5_ovr", n_ovr, ovr0 + 1);
      check("t5_valid_held", {31'd0, rx_valid}, 32'd1);
      check("t5_data_held", {24'd0, rx_data}, 32'h11);
      check("t5_acc_none", n_acc, acc0);
      rx_ready = 1'b1;
      wait_clks(3);
      check("t5_valid_drop", {31'd0, rx_valid}, 32'd0);
      check("t5_acc", n_acc, acc0 + 1);

      // 6: reset mid-frame, then a clean frame
      acc0 = n_acc;
      rx = 1'b0;
      wait_clks(CPB);
      for (int i = 0; i < 3; i++) begin
         rx = (8'h5A >> i) & 8'h01;
         wait_clks(CPB);
      end
      reset = 1'b1;
      rx    = 1'b1;
      #2;
      check("t6_rst_data", {24'd0, rx_data}, 32'd0);
      check("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_flags", {30'd0, frame_err, overrun}, 32'd0);
      wait_clks(2);
      reset = 1'b0;
      wait_clks(20);
      check("t6_acc_none", n_acc, acc0);
      sb.push_back(8'h96);
      send_byte(8'h96, 1'b1);
      wait_clks(10);
      check("t6_acc", n_acc, acc0 + 1);
      check("t6_sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
